// File: rtl/rock_controller.sv
// rtl/rock_controller.sv - cradle rocking controller driven by a stress-low indication
module rock_controller #(
    parameter int WINDOW       = 16,
    parameter int THRESH       = 12,
    parameter int CALM_WINDOWS = 4,
    parameter int START_LEVEL  = 4,
    parameter int HALF_MAX     = 12,
    parameter int SPEED_STEP   = 32
) (
    input  logic       clk,
    input  logic       r,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    input  logic       stress_laag,
    output logic [7:0] motor_speed,
    output logic       motor_dir,
    output logic       rocking,
    output logic [2:0] level,
    output logic       calm
);

    localparam int WW = $clog2(WINDOW);
    localparam int LW = $clog2(WINDOW + 1);
    localparam int PW = $clog2(HALF_MAX);
    localparam int CW = $clog2(CALM_WINDOWS + 1);

    typedef enum logic [1:0] {IDLE, ROCK, STOPPING} state_t;

    state_t          state;
    logic [PW-1:0]   phase_cnt;
    logic [WW-1:0]   win_cnt;
    logic [LW-1:0]   low_cnt;
    logic [CW-1:0]   calm_cnt;
    logic [PW-1:0]   hp_last;
    logic [LW-1:0]   low_fin;
    logic            toggle;

    function automatic logic [7:0] speed_of(input logic [2:0] l);
        return 8'(int'(l) * SPEED_STEP);
    endfunction

    // Last phase value of the current half period; follows level immediately so a
    // shortened period is caught by the >= compare on the next tick.
    always_comb begin
        hp_last = PW'(HALF_MAX - 1 - int'(level));
        low_fin = low_cnt + LW'(stress_laag);
        toggle  = (phase_cnt >= hp_last);
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            state       <= IDLE;
            level       <= 3'd0;
            motor_speed <= 8'd0;
            motor_dir   <= 1'b0;
            rocking     <= 1'b0;
            calm        <= 1'b0;
            phase_cnt   <= '0;
            win_cnt     <= '0;
            low_cnt     <= '0;
            calm_cnt    <= '0;
        end else begin
            calm <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state       <= ROCK;
                        level       <= 3'(START_LEVEL);
                        motor_speed <= speed_of(3'(START_LEVEL));
                        motor_dir   <= 1'b0;
                        rocking     <= 1'b1;
                        phase_cnt   <= '0;
                        win_cnt     <= '0;
                        low_cnt     <= '0;
                        calm_cnt    <= '0;
                    end
                end
                ROCK, STOPPING: begin
                    if (stop || (state == STOPPING && tick && toggle)) begin
                        // Abort and clean finish share the return to idle; only the
                        // clean finish at a direction reversal reports calm.
                        state       <= IDLE;
                        level       <= 3'd0;
                        motor_speed <= 8'd0;
                        motor_dir   <= 1'b0;
                        rocking     <= 1'b0;
                        calm        <= !stop;
                        phase_cnt   <= '0;
                        win_cnt     <= '0;
                        low_cnt     <= '0;
                        calm_cnt    <= '0;
                    end else if (tick) begin
                        if (toggle) begin
                            motor_dir <= ~motor_dir;
                            phase_cnt <= '0;
                        end else begin
                            phase_cnt <= phase_cnt + PW'(1);
                        end
                        if (state == ROCK) begin
                            if (win_cnt == WW'(WINDOW - 1)) begin
                                win_cnt <= '0;
                                low_cnt <= '0;
                                if (low_fin >= LW'(THRESH)) begin
                                    if (level > 3'd1) begin
                                        level       <= level - 3'd1;
                                        motor_speed <= speed_of(level - 3'd1);
                                        calm_cnt    <= '0;
                                    end else begin
                                        calm_cnt <= calm_cnt + CW'(1);
                                        if (calm_cnt + CW'(1) == CW'(CALM_WINDOWS))
                                            state <= STOPPING;
                                    end
                                end else begin
                                    if (level < 3'd7) begin
                                        level       <= level + 3'd1;
                                        motor_speed <= speed_of(level + 3'd1);
                                    end
                                    calm_cnt <= '0;
                                end
                            end else begin
                                win_cnt <= win_cnt + WW'(1);
                                low_cnt <= low_fin;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rock_controller.sv
// tb/tb_rock_controller.sv - scoreboard bench for rock_controller
module tb_rock_controller;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick = 1'b0;
    logic       stress_laag = 1'b0;
    logic [7:0] motor_speed;
    logic       motor_dir;
    logic       rocking;
    logic [2:0] level;
    logic       calm;

    rock_controller dut (
        .clk(clk), .r(r), .start(start), .stop(stop), .tick(tick),
        .stress_laag(stress_laag), .motor_speed(motor_speed),
        .motor_dir(motor_dir), .rocking(rocking), .level(level), .calm(calm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int lvl;
        bit rock;
        bit cl;
    } ev_t;

    ev_t evq[$];
    int  dirq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  t0 = 0;
    bit  mon_en = 1'b0;
    bit  done = 1'b0;
    bit  dir_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ev(input int st, input int lv, input bit rk, input bit cl);
        ev_t e;
        e.stamp = st;
        e.lvl   = lv;
        e.rock  = rk;
        e.cl    = cl;
        evq.push_back(e);
    endtask

    task automatic drive(input bit tk, input bit s, input bit st, input bit sp, input bit rr);
        tick        = tk;
        stress_laag = s;
        start       = st;
        stop        = sp;
        r           = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n, input bit s);
        repeat (n) drive(1'b1, s, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_start();
        t0 = cyc + 1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check_ev(input ev_t e);
        if (e.stamp >= 0) chk($sformatf("ev@%0d stamp", e.stamp), cyc - t0, e.stamp);
        chk($sformatf("ev@%0d level", e.stamp), int'(level), e.lvl);
        chk($sformatf("ev@%0d speed", e.stamp), int'(motor_speed), e.lvl * 32);
        chk($sformatf("ev@%0d rocking", e.stamp), int'(rocking), int'(e.rock));
        chk($sformatf("ev@%0d calm", e.stamp), int'(calm), int'(e.cl));
    endtask

    // Monitor: pops an expected record whenever the visible state changes.
    initial begin
        logic [13:0] prev;
        logic        p_dir;
        wait (mon_en);
        @(negedge clk);
        check_ev(evq.pop_front());
        chk("reset dir", int'(motor_dir), 0);
        prev  = {level, motor_speed, rocking, calm};
        p_dir = motor_dir;
        while (!done) begin
            @(negedge clk);
            if ({level, motor_speed, rocking, calm} !== prev) begin
                if (evq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected change at stamp %0d: level %0d speed %0d rocking %0d calm %0d",
                             cyc - t0, level, motor_speed, rocking, calm);
                end else begin
                    check_ev(evq.pop_front());
                end
                prev = {level, motor_speed, rocking, calm};
            end
            if (motor_dir !== p_dir) begin
                if (dir_chk) begin
                    if (dirq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected dir change at stamp %0d: got none expected", cyc - t0);
                    end else begin
                        chk("dir toggle stamp", cyc - t0, dirq.pop_front());
                    end
                end
                p_dir = motor_dir;
            end
        end
        chk("pending events", evq.size(), 0);
        chk("pending toggles", dirq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with start asserted: start must be ignored.
        r = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r = 1'b1;
        start = 1'b0;
        ev(-1, 0, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle(2);

        // Constant stress: level climbs and saturates, half period shortens.
        dir_chk = 1'b1;
        foreach (dirq[i]) dirq.delete(i);
        dirq.push_back(8);  dirq.push_back(16); dirq.push_back(23); dirq.push_back(30);
        dirq.push_back(36); dirq.push_back(42); dirq.push_back(48); dirq.push_back(53);
        dirq.push_back(58); dirq.push_back(63); dirq.push_back(68); dirq.push_back(71);
        ev(0, 4, 1'b1, 1'b0);
        ev(16, 5, 1'b1, 1'b0);
        ev(32, 6, 1'b1, 1'b0);
        ev(48, 7, 1'b1, 1'b0);
        ev(71, 0, 1'b0, 1'b0);
        do_start();
        ticks(70, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        dir_chk = 1'b0;

        // Constant calm: descend to level 1, four calm windows, stop at next reversal.
        ev(0, 4, 1'b1, 1'b0);
        ev(16, 3, 1'b1, 1'b0);
        ev(32, 2, 1'b1, 1'b0);
        ev(48, 1, 1'b1, 1'b0);
        ev(122, 0, 1'b0, 1'b1);
        ev(123, 0, 1'b0, 1'b0);
        do_start();
        ticks(125, 1'b1);
        idle(2);

        // Threshold boundary (11 then 12 lows), then abort at level 6 mid-window.
        ev(0, 4, 1'b1, 1'b0);
        ev(16, 5, 1'b1, 1'b0);
        ev(32, 4, 1'b1, 1'b0);
        ev(48, 5, 1'b1, 1'b0);
        ev(64, 6, 1'b1, 1'b0);
        ev(71, 0, 1'b0, 1'b0);
        do_start();
        ticks(11, 1'b1);
        ticks(5, 1'b0);
        ticks(4, 1'b0);
        ticks(12, 1'b1);
        ticks(38, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Reset at level 6 mid-window, then a fresh start.
        ev(0, 4, 1'b1, 1'b0);
        ev(16, 5, 1'b1, 1'b0);
        ev(32, 6, 1'b1, 1'b0);
        ev(40, 0, 1'b0, 1'b0);
        do_start();
        ticks(39, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        ev(0, 4, 1'b1, 1'b0);
        ev(16, 5, 1'b1, 1'b0);
        ev(21, 0, 1'b0, 1'b0);
        do_start();
        ticks(20, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        done = 1'b1;
    end

endmodule

// File: doc/rock_controller.md
Name: rock_controller

Overview:
- Drives the cradle rocking motor using the 1-bit stress-low indication produced by the stress evaluator.
- Counts stress-low samples per evaluation window and moves rocking intensity down (calming) or up (still stressed).
- Stops rocking cleanly, at a direction reversal, once the baby stays calm at minimum intensity.
- Sits between the stress evaluator and the motor driver.

Parameters:
- WINDOW, 16: evaluation window length, in tick strobes.
- THRESH, 12: minimum stress-low samples per window for the window to count as "calm".
- CALM_WINDOWS, 4: consecutive calm windows at level 1 required before stopping.
- START_LEVEL, 4: intensity level loaded on start.
- HALF_MAX, 12: half-period base; half_period = HALF_MAX - level, in ticks.
- SPEED_STEP, 32: motor_speed = level * SPEED_STEP.

Ports:
- clk  in  1  system clock, rising edge
- r  in  1  reset, synchronous, active-low
- start  in  1  request to begin rocking (1-cycle pulse)
- stop  in  1  abort rocking immediately
- tick  in  1  time-base strobe, 1 clk wide
- stress_laag  in  1  stress-low indication, sampled at posedge clk only when tick=1
- motor_speed  out  8  registered motor speed
- motor_dir  out  1  registered rocking direction
- rocking  out  1  high while in ROCK or STOPPING
- level  out  3  current intensity, 0..7
- calm  out  1  1-cycle pulse on a normal (calm) stop

Behaviour:
- Reset (r=0 at posedge clk): state=IDLE, level=0, motor_speed=0, motor_dir=0, rocking=0, calm=0, all counters 0. Reset overrides all other inputs.
- All outputs are registered. Changes appear the cycle after the causing edge.
- IDLE:
  - Outputs 0.
  - start=1 and stop=0 → ROCK, with level=START_LEVEL and all counters cleared.
- ROCK: only tick cycles advance counters.
  - Phase counter:
    - Increments on each tick.
    - When phase_cnt >= half_period-1: toggle motor_dir and clear phase_cnt.
    - A level change takes effect on the next tick; the >= compare handles a shortened half period.
  - Window counter:
    - Counts ticks 0..WINDOW-1.
    - low_cnt increments on each tick with stress_laag=1, including the window's last tick.
  - Window end (tick with win_cnt=WINDOW-1), using the final low_cnt:
    - low_cnt >= THRESH and level > 1: level -= 1, calm_cnt = 0.
    - low_cnt >= THRESH and level = 1: calm_cnt += 1.
    - low_cnt < THRESH: level += 1, saturating at 7; calm_cnt = 0.
    - Then clear win_cnt and low_cnt.
  - When calm_cnt reaches CALM_WINDOWS → STOPPING.
  - start is ignored outside IDLE.
- STOPPING:
  - Continue rocking at level 1.
  - On the next direction toggle: motor_speed=0, level=0, calm=1 for one cycle, → IDLE.
- stop=1 in ROCK or STOPPING: → IDLE next cycle with outputs 0 and no calm pulse.
- stop has priority over start in the same cycle.
- motor_speed always equals level*SPEED_STEP (max 224, fits 8 bits).
- Level arithmetic saturates at both 1 and 7; no wrap-around.
- tick=0: all counters and outputs hold.

Test Plan:
- r=0 for 2 cycles with start=1 → all outputs 0, state IDLE; start ignored while r=0.
- start, tick=1 every cycle, stress_laag=0 → level 4, speed 128, motor_dir toggles every 8 ticks; after tick 16: level 5, speed 160, toggle every 7; after 3 more windows: level 7, speed 224, saturated, toggle every 5.
- start, tick=1, stress_laag=1 constant → level 4→3→2→1 at ticks 16/32/48; calm_cnt reaches 4 at tick 112 → STOPPING; at the next toggle, speed 0 and calm pulses for 1 cycle; rocking=0.
- Threshold boundary: window with 11 of 16 stress_laag=1 → level +1; window with 12 of 16 → level −1.
- stop at level 6 mid-window → next cycle IDLE, speed 0, no calm; start and stop in the same cycle from IDLE → stays IDLE.
- r=0 at level 6 mid-window with tick=1 → next edge all outputs 0; after release, a start restarts at level 4 with a fresh window count.
